// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD unit.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } gcd_state_t;

    // Operand mux selects: load a fresh operand or take the difference.
    localparam logic SEL_DIFF = 1'b0;
    localparam logic SEL_LOAD = 1'b1;

endpackage

// File: rtl/mux2to1_nbits.sv
// Plain SIZE-bit two-input multiplexer; sel=1 picks in1.
module mux2to1_nbits #(
    parameter int unsigned SIZE = 8
) (
    input  logic [SIZE-1:0] in0,
    input  logic [SIZE-1:0] in1,
    input  logic            sel,
    output logic [SIZE-1:0] out
);

    // Select between the two inputs.
    always_comb begin
        out = sel ? in1 : in0;
    end

endmodule

// File: rtl/gcd_nbits.sv
// Sequential GCD by repeated subtraction with ready/valid on both sides.
module gcd_nbits
    import gcd_pkg::*;
#(
    parameter int unsigned SIZE = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a_in,
    input  logic [SIZE-1:0] b_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] gcd_out
);

    gcd_state_t      state;
    logic [SIZE-1:0] reg_a;
    logic [SIZE-1:0] reg_b;
    logic [SIZE-1:0] next_a;
    logic [SIZE-1:0] next_b;
    logic [SIZE-1:0] diff_ab;
    logic [SIZE-1:0] diff_ba;
    logic            a_zero;
    logic            b_zero;
    logic            a_eq_b;
    logic            a_gt_b;
    logic            calc_done;
    logic            mux_sel;
    logic            ld_a;
    logic            ld_b;

    // Comparator and subtractors; the larger operand is always the minuend, so no borrow is kept.
    always_comb begin
        diff_ab   = reg_a - reg_b;
        diff_ba   = reg_b - reg_a;
        a_zero    = (reg_a == '0);
        b_zero    = (reg_b == '0);
        a_eq_b    = (reg_a == reg_b);
        a_gt_b    = (reg_a > reg_b);
        calc_done = b_zero || a_zero || a_eq_b;
    end

    // Mux select and per-register load enables; at most one register moves per CALC cycle.
    always_comb begin
        mux_sel = SEL_DIFF;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        case (state)
            IDLE: begin
                mux_sel = SEL_LOAD;
                ld_a    = in_valid && in_ready;
                ld_b    = in_valid && in_ready;
            end
            CALC: begin
                if (!calc_done) begin
                    ld_a = a_gt_b;
                    ld_b = !a_gt_b;
                end
            end
            default: ;
        endcase
    end

    mux2to1_nbits #(.SIZE(SIZE)) u_mux_a (
        .in0 (diff_ab),
        .in1 (a_in),
        .sel (mux_sel),
        .out (next_a)
    );

    mux2to1_nbits #(.SIZE(SIZE)) u_mux_b (
        .in0 (diff_ba),
        .in1 (b_in),
        .sel (mux_sel),
        .out (next_b)
    );

    // Operand registers, written only when their load enable is set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_a <= '0;
            reg_b <= '0;
        end else begin
            if (ld_a) reg_a <= next_a;
            if (ld_b) reg_b <= next_b;
        end
    end

    // Controller FSM with registered handshake outputs and result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gcd_out   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= CALC;
                        in_ready <= 1'b0;
                    end
                end
                CALC: begin
                    if (calc_done) begin
                        // Zero checks first: gcd(x,0)=x and gcd(0,x)=x.
                        if (b_zero) begin
                            gcd_out <= reg_a;
                        end else if (a_zero) begin
                            gcd_out <= reg_b;
                        end else begin
                            gcd_out <= reg_a;
                        end
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_nbits.sv
// Scoreboard bench for gcd_nbits: driver pushes expectations, monitor pops on each result.
module tb_gcd_nbits;

    localparam int unsigned SIZE = 8;

    typedef struct {
        logic [SIZE-1:0] g;
        int              lat;
        int              acc;
    } exp_t;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a_in;
    logic [SIZE-1:0] b_in;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] gcd_out;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   force_ready = 1'b1;
    bit   rand_ready  = 1'b0;
    exp_t sb[$];

    gcd_nbits #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gcd_out   (gcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: fixed or randomly stalling out_ready, changed just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
        end
    end

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference GCD by Euclid's remainder method.
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Cycles from accept to out_valid: one per subtraction plus the final step.
    function automatic int ref_lat(input int a, input int b);
        int steps = 0;
        while (a != 0 && b != 0 && a != b) begin
            if (a > b) a = a - b;
            else b = b - a;
            steps++;
        end
        return steps + 1;
    endfunction

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [SIZE-1:0] g, input int lat);
        exp_t e;
        bit   ok = 1'b0;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.g   = g;
                e.lat = lat;
                e.acc = cyc + 1;
                sb.push_back(e);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", ok, 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", ok, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each new result, checks hold under stall and drop after handshake.
    initial begin
        bit              prev_valid = 1'b0;
        bit              prev_ready = 1'b0;
        logic [SIZE-1:0] prev_gcd   = '0;
        exp_t            e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (prev_valid && prev_ready) begin
                    chk("valid_drop", out_valid == 1'b0, out_valid, 0);
                    chk("ready_back", in_ready == 1'b1, in_ready, 1);
                end else if (prev_valid) begin
                    chk("hold_valid", out_valid == 1'b1, out_valid, 1);
                    chk("hold_gcd", gcd_out == prev_gcd, gcd_out, prev_gcd);
                end
                if (out_valid && !prev_valid) begin
                    if (sb.size() == 0) begin
                        chk("spurious_result", sb.size() != 0, gcd_out, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("gcd_value", gcd_out == e.g, gcd_out, e.g);
                        chk("latency", (cyc - e.acc) == e.lat, cyc - e.acc, e.lat);
                        chk("in_ready_low", in_ready == 1'b0, in_ready, 0);
                    end
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_gcd   = gcd_out;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ra;
        int rb;
        bit seen;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("rst_in_ready", in_ready == 1'b1, in_ready, 1);
        chk("rst_gcd_out", gcd_out == '0, gcd_out, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic case: two subtractions then the equal step.
        send(8'd12, 8'd8, 8'd4, 3);
        wait_drain();

        // Zero and equal operands finish on the first CALC cycle.
        send(8'd0, 8'd0, 8'd0, 1);
        send(8'd0, 8'd9, 8'd9, 1);
        send(8'd9, 8'd0, 8'd9, 1);
        send(8'd7, 8'd7, 8'd7, 1);
        wait_drain();

        // Worst case in both operand orders.
        send(8'd255, 8'd1, 8'd1, 255);
        send(8'd1, 8'd255, 8'd1, 255);
        wait_drain();

        // Backpressure: result held, in_ready low, new operands ignored.
        force_ready = 1'b0;
        @(posedge clk);
        #1;
        send(8'd12, 8'd8, 8'd4, 3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_result_seen", seen, seen, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            a_in     = 8'd30;
            b_in     = 8'd6;
            @(negedge clk);
            chk("bp_out_valid", out_valid == 1'b1, out_valid, 1);
            chk("bp_in_ready", in_ready == 1'b0, in_ready, 0);
            chk("bp_gcd_out", gcd_out == 8'd4, gcd_out, 4);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        force_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", out_valid == 1'b0, out_valid, 0);
        chk("bp_release_ready", in_ready == 1'b1, in_ready, 1);
        wait_drain();

        // Reset in the middle of a long computation discards it.
        send(8'd255, 8'd1, 8'd1, 255);
        repeat (50) @(posedge clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("midrst_in_ready", in_ready == 1'b1, in_ready, 1);
        chk("midrst_gcd_out", gcd_out == '0, gcd_out, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'd6, 8'd4, 8'd2, 3);
        wait_drain();

        // Random operands with a randomly stalling consumer.
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            send(ra[SIZE-1:0], rb[SIZE-1:0], ref_gcd(ra, rb) & 8'hff, ref_lat(ra, rb));
        end
        wait_drain();
        rand_ready = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size() == 0, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
